// File: rtl/game_pkg.sv
// Shared tile-map constants and background-writer state encoding.
// Also used by game_engine, so keep changes here backward compatible.
package game_pkg;

  localparam int TILE_COLS   = 40;
  localparam int TILE_ROWS   = 30;
  localparam int TILE_COUNT  = TILE_COLS * TILE_ROWS;
  localparam int TILE_ADDR_W = 16;
  localparam int TILE_DATA_W = 32;
  localparam int SWEEP_W     = 11;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } bg_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: starting at ptr and wrapping, the
// first set bit of valid wins; returns it one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               grant_any
);

  // Scan from farthest to nearest so the last hit is the one closest to ptr
  always_comb begin
    int j;
    grant     = '0;
    idx       = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (valid[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        idx       = PTR_W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bg_write_arbiter.sv
// Background tile-RAM write arbiter: round-robin among requesters, with a
// full-map clear sweep that takes priority over all requesters.
module bg_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TILE_COLS = game_pkg::TILE_COLS,
  parameter int TILE_ROWS = game_pkg::TILE_ROWS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    clear_req,
  output logic                                    clear_busy,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [game_pkg::TILE_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [game_pkg::TILE_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic                                    bg_wea,
  output logic [game_pkg::TILE_ADDR_W-1:0]        bg_ram_addr,
  output logic [game_pkg::TILE_DATA_W-1:0]        bg_ram_data,
  output logic                                    drop_err
);

  import game_pkg::*;

  localparam int TILE_TOTAL = TILE_COLS * TILE_ROWS;
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(TILE_TOTAL - 1);

  bg_state_t                state, state_next;
  logic [PTR_W-1:0]         rr_ptr;
  logic [SWEEP_W-1:0]       sweep_cnt;
  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_any;
  logic [TILE_ADDR_W-1:0]   sel_addr;
  logic [TILE_DATA_W-1:0]   sel_data;
  logic                     wea_q, drop_q, busy_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (grant_idx),
    .grant_any (grant_any)
  );

  // Mux the granted requester's address and data onto the write path
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*TILE_ADDR_W +: TILE_ADDR_W];
        sel_data = req_data[i*TILE_DATA_W +: TILE_DATA_W];
      end
    end
  end

  // Next state and ready: clear beats requesters; nothing is accepted in reset
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      ST_ARB: begin
        if (clear_req) state_next = ST_CLEAR;
        else           req_ready  = grant;
      end
      ST_CLEAR: begin
        if (!clear_req && sweep_cnt == SWEEP_LAST) state_next = ST_ARB;
      end
      default: state_next = ST_ARB;
    endcase
    if (reset) req_ready = '0;
  end

  // State, pointer, sweep counter and registered RAM port; a clear pulse
  // writes address 0 immediately so the sweep starts on the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ARB;
      rr_ptr      <= '0;
      sweep_cnt   <= '0;
      wea_q       <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      bg_ram_addr <= '0;
      bg_ram_data <= '0;
    end else begin
      state  <= state_next;
      wea_q  <= 1'b0;
      drop_q <= 1'b0;
      busy_q <= 1'b0;
      if (clear_req) begin
        wea_q       <= 1'b1;
        busy_q      <= 1'b1;
        bg_ram_addr <= '0;
        bg_ram_data <= '0;
        sweep_cnt   <= SWEEP_W'(1);
      end else if (state == ST_CLEAR) begin
        wea_q       <= 1'b1;
        busy_q      <= 1'b1;
        bg_ram_addr <= TILE_ADDR_W'(sweep_cnt);
        bg_ram_data <= '0;
        sweep_cnt   <= (sweep_cnt == SWEEP_LAST) ? '0 : sweep_cnt + 1'b1;
      end else if (grant_any) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        if (sel_addr < TILE_ADDR_W'(TILE_TOTAL)) begin
          wea_q       <= 1'b1;
          bg_ram_addr <= sel_addr;
          bg_ram_data <= sel_data;
        end else begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  // Strobes are masked during reset so a write accepted just before reset
  // never reaches the RAM
  assign bg_wea     = wea_q  & ~reset;
  assign drop_err   = drop_q & ~reset;
  assign clear_busy = busy_q & ~reset;

endmodule

// File: tb/tb_bg_write_arbiter.sv
// Randomized and directed bench for bg_write_arbiter against a
// transaction-level reference model of grants, sweeps and drops.
module tb_bg_write_arbiter;

  localparam int N  = 4;
  localparam int TC = 1200;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_req;
  logic            clear_busy;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_addr;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            bg_wea;
  logic [15:0]     bg_ram_addr;
  logic [31:0]     bg_ram_data;
  logic            drop_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pointer, writes still owed by a sweep, expected outputs
  int          m_ptr       = 0;
  int          m_remaining = 0;
  int          m_grant     = -1;
  logic        exp_wea     = 1'b0;
  logic        exp_drop    = 1'b0;
  logic        exp_busy    = 1'b0;
  logic [15:0] exp_addr    = '0;
  logic [31:0] exp_data    = '0;

  bg_write_arbiter #(.NUM_REQ(N), .TILE_COLS(40), .TILE_ROWS(30)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .bg_wea      (bg_wea),
    .bg_ram_addr (bg_ram_addr),
    .bg_ram_data (bg_ram_data),
    .drop_err    (drop_err)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelPick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic setReq(input int i, input logic [15:0] a, input logic [31:0] d);
    req_valid[i]          = 1'b1;
    req_addr[16*i +: 16]  = a;
    req_data[32*i +: 32]  = d;
  endtask

  function automatic logic [15:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return 16'($urandom_range(0, TC - 1));
    else if (r == 6) return 16'(TC - 1);
    else if (r == 7) return 16'(TC);
    else if (r == 8) return 16'd0;
    else             return 16'($urandom_range(TC + 1, 65535));
  endfunction

  // One clock: check outputs mid-cycle, advance the model, return after the edge
  task automatic applyStimulus();
    int          g;
    logic [N-1:0] er;
    logic [15:0] a;
    @(negedge clk);
    g  = -1;
    er = '0;
    if (!reset && !clear_req && m_remaining == 0) begin
      g = modelPick();
      if (g >= 0) er[g] = 1'b1;
    end
    checkOutput("req_ready", 64'(req_ready), 64'(er));
    if (reset) begin
      checkOutput("wea_in_reset",  64'(bg_wea),     64'(0));
      checkOutput("busy_in_reset", 64'(clear_busy), 64'(0));
      checkOutput("drop_in_reset", 64'(drop_err),   64'(0));
    end else begin
      checkOutput("bg_wea",      64'(bg_wea),      64'(exp_wea));
      checkOutput("clear_busy",  64'(clear_busy),  64'(exp_busy));
      checkOutput("drop_err",    64'(drop_err),    64'(exp_drop));
      checkOutput("bg_ram_addr", 64'(bg_ram_addr), 64'(exp_addr));
      checkOutput("bg_ram_data", 64'(bg_ram_data), 64'(exp_data));
    end
    if (reset) begin
      m_ptr = 0; m_remaining = 0;
      exp_wea = 0; exp_drop = 0; exp_busy = 0; exp_addr = '0; exp_data = '0;
    end else begin
      exp_wea = 0; exp_drop = 0; exp_busy = 0;
      if (clear_req) begin
        exp_wea = 1; exp_busy = 1; exp_addr = '0; exp_data = '0;
        m_remaining = TC - 1;
      end else if (m_remaining > 0) begin
        exp_wea = 1; exp_busy = 1; exp_addr = 16'(TC - m_remaining); exp_data = '0;
        m_remaining--;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % N;
        a = req_addr[16*g +: 16];
        if (int'(a) < TC) begin
          exp_wea = 1; exp_addr = a; exp_data = req_data[32*g +: 32];
        end else begin
          exp_drop = 1;
        end
      end
    end
    m_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic runIdle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      applyStimulus();
      if (m_grant >= 0) req_valid[m_grant] = 1'b0;
    end
  endtask

  task automatic pulseClear();
    clear_req = 1'b1;
    applyStimulus();
    clear_req = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    clear_req = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    $display("[TB] start");
    repeat (2) applyStimulus();
    reset = 1'b0;

    // req0 and req2 held valid continuously: grants alternate
    setReq(0, 16'd10, 32'h1000_0000);
    setReq(2, 16'd20, 32'h2000_0000);
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      if (m_grant >= 0) setReq(m_grant, 16'(m_grant * 100 + k), $urandom);
    end
    req_valid = '0;
    runIdle(2);

    // clear with req1 pending: serviced only after the full sweep
    setReq(1, 16'd5, 32'h0000_01A5);
    pulseClear();
    runIdle(TC + 5);

    // out-of-range write is dropped, last tile written normally
    setReq(3, 16'(TC), 32'hDEAD_BEEF);
    runIdle(3);
    setReq(3, 16'(TC - 1), 32'hCAFE_F00D);
    runIdle(3);

    // restart a sweep half way through
    pulseClear();
    runIdle(599);
    pulseClear();
    runIdle(TC + 3);

    // reset part way through a sweep with req0 waiting
    pulseClear();
    runIdle(299);
    setReq(0, 16'd7, 32'h0000_0077);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    runIdle(4);

    // randomized traffic with occasional clears and resets
    for (int c = 0; c < 4000; c++) begin
      clear_req = ($urandom_range(0, 599) == 0);
      reset     = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) setReq(i, randAddr(), $urandom);
      applyStimulus();
      if (m_grant >= 0) req_valid[m_grant] = 1'b0;
    end
    clear_req = 1'b0;
    reset     = 1'b0;
    runIdle(TC + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
